// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
//   Turns LCD command/data bytes into the 4-bit-mode write sequence of an
//   I2C port expander (PCF8574-style: P7..P4 = D7..D4, P3 = backlight,
//   P2 = EN, P1 = RW, P0 = RS). Each byte becomes four expander writes
//   (high nibble with EN high then low, low nibble with EN high then low).
//   Each write is handed to an external I2C write controller and followed
//   by an idle gap. Clear/home commands get an extra long gap.
//
// Build option:
//   LCD_INIT_EN  when defined, the 4-bit init sequence (0x3,0x3,0x3,0x2 nibbles,
//                then 0x28,0x0C,0x06,0x01) runs after power-up, before the
//                first request is accepted.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   req_valid  requester has a byte to send
//   req_rs     0 = command, 1 = data
//   req_byte   byte to send to the LCD
//   req_ready  high only in IDLE; byte taken when req_valid & req_ready
//   backlight  expander P3 value, sampled as each write is issued
//   i2c_start  one-cycle start pulse to the I2C write controller
//   i2c_data   {17'b0, I2C_ADDR, expander byte}, stable for a whole write
//   i2c_busy   write controller transfer in progress
//   i2c_done   write controller finished
//   i2c_ack    write controller saw both acks
//   seq_busy   high in every state except IDLE
//   ack_err    sticky: a write ended without ack or timed out
module lcd_cmd_sequencer #(
    parameter logic [6:0]  I2C_ADDR  = 7'h27,
    parameter logic [15:0] GAP_CYC   = 16'd200,
    parameter logic [15:0] LONG_CYC  = 16'd4000,
    parameter logic [19:0] PWRUP_CYC = 20'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_rs,
    input  logic [7:0]  req_byte,
    output logic        req_ready,
    input  logic        backlight,
    output logic        i2c_start,
    output logic [31:0] i2c_data,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        seq_busy,
    output logic        ack_err
);

    typedef enum logic [2:0] {
        PWRUP,
`ifdef LCD_INIT_EN
        INIT,
`endif
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    localparam logic [19:0] PWRUP_LAST   = PWRUP_CYC - 20'd1;
    localparam logic [15:0] GAP_LAST     = GAP_CYC - 16'd1;
    localparam logic [15:0] LONG_LAST    = LONG_CYC - 16'd1;
    localparam logic [9:0]  BUSY_TO_LAST = 10'd1023;

    state_t      state;
    logic [1:0]  phase;     // 0: hi/EN=1, 1: hi/EN=0, 2: lo/EN=1, 3: lo/EN=0
    logic [19:0] cnt;       // shared by power-up wait, busy timeout and gap
    logic        gap_ext;   // GAP is in its second (LONG_CYC) stretch
    logic [7:0]  cur_byte;
    logic        cur_rs;
    logic        long_cmd;
    logic [15:0] gap_last;

`ifdef LCD_INIT_EN
    logic [3:0]  init_idx;  // next init step; bit 3 set once all steps issued

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h03;
            3'd3:             init_rom = 8'h02;
            3'd4:             init_rom = 8'h28;
            3'd5:             init_rom = 8'h0C;
            3'd6:             init_rom = 8'h06;
            default:          init_rom = 8'h01;
        endcase
    endfunction
`endif

    // Full I2C word for one write: the phase picks the nibble and EN level.
    function automatic logic [31:0] write_word(input logic [7:0] b, input logic rs,
                                               input logic [1:0] ph, input logic bl);
        logic [3:0] nib;
        nib = ph[1] ? b[3:0] : b[7:4];
        return {17'd0, I2C_ADDR, nib, bl, ~ph[0], 1'b0, rs};
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long settle time. The
    // single-nibble init steps carry 0x03/0x02 with rs=0, so they also
    // fall in here and get their long gap without extra logic.
    assign long_cmd = !cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02 || cur_byte == 8'h03);
    assign gap_last = gap_ext ? LONG_LAST : GAP_LAST;

    // NOTE: every register here uses non-blocking assignment, so all of them
    // update together on the edge and the order of statements does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PWRUP;
            phase     <= 2'd0;
            cnt       <= 20'd0;
            gap_ext   <= 1'b0;
            cur_byte  <= 8'd0;
            cur_rs    <= 1'b0;
            req_ready <= 1'b0;
            i2c_start <= 1'b0;
            i2c_data  <= 32'd0;
            seq_busy  <= 1'b1;
            ack_err   <= 1'b0;
`ifdef LCD_INIT_EN
            init_idx  <= 4'd0;
`endif
        end else begin
            case (state)
                PWRUP: begin
                    if (cnt == PWRUP_LAST) begin
                        cnt <= 20'd0;
`ifdef LCD_INIT_EN
                        state <= INIT;
`else
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        seq_busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end

`ifdef LCD_INIT_EN
                // Nibble-only steps start at phase 2 so just the low nibble
                // of the ROM byte goes out as one EN pulse pair.
                INIT: begin
                    cur_byte  <= init_rom(init_idx[2:0]);
                    cur_rs    <= 1'b0;
                    phase     <= init_idx[2] ? 2'd0 : 2'd2;
                    i2c_data  <= write_word(init_rom(init_idx[2:0]), 1'b0,
                                            init_idx[2] ? 2'd0 : 2'd2, backlight);
                    i2c_start <= 1'b1;
                    init_idx  <= init_idx + 4'd1;
                    state     <= ISSUE;
                end
`endif

                IDLE: begin
                    if (req_valid && req_ready) begin
                        cur_byte  <= req_byte;
                        cur_rs    <= req_rs;
                        phase     <= 2'd0;
                        i2c_data  <= write_word(req_byte, req_rs, 2'd0, backlight);
                        i2c_start <= 1'b1;
                        req_ready <= 1'b0;
                        seq_busy  <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                // i2c_start is high for exactly the one cycle spent here.
                ISSUE: begin
                    i2c_start <= 1'b0;
                    cnt       <= 20'd0;
                    state     <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (i2c_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt[9:0] == BUSY_TO_LAST) begin
                        ack_err <= 1'b1;
                        cnt     <= 20'd0;
                        gap_ext <= 1'b0;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end

                WAIT_DONE: begin
                    if (!i2c_busy && i2c_done) begin
                        if (!i2c_ack) begin
                            ack_err <= 1'b1;
                        end
                        cnt     <= 20'd0;
                        gap_ext <= 1'b0;
                        state   <= GAP;
                    end
                end

                // The long gap is a second stretch after the normal one, so
                // both comparisons stay 16 bits wide.
                GAP: begin
                    if (cnt[15:0] == gap_last) begin
                        cnt <= 20'd0;
                        if (phase == 2'd3 && long_cmd && !gap_ext) begin
                            gap_ext <= 1'b1;
                        end else if (phase != 2'd3) begin
                            phase     <= phase + 2'd1;
                            i2c_data  <= write_word(cur_byte, cur_rs, phase + 2'd1, backlight);
                            i2c_start <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            phase <= 2'd0;
`ifdef LCD_INIT_EN
                            if (!init_idx[3]) begin
                                state <= INIT;
                            end else begin
                                state     <= IDLE;
                                req_ready <= 1'b1;
                                seq_busy  <= 1'b0;
                            end
`else
                            state     <= IDLE;
                            req_ready <= 1'b1;
                            seq_busy  <= 1'b0;
`endif
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end

                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Testbench for lcd_cmd_sequencer: randomised requests and a behavioural
// I2C writer, checked against a byte-level model of the expander writes.
module tb_lcd_cmd_sequencer;

    localparam logic [15:0] GAP  = 16'd20;
    localparam logic [15:0] LONG = 16'd400;
    localparam logic [19:0] PWR  = 20'd300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rs = 1'b0;
    logic [7:0]  req_byte = 8'd0;
    logic        backlight = 1'b1;
    logic        i2c_busy, i2c_done, i2c_ack;
    logic        req_ready, i2c_start, seq_busy, ack_err;
    logic [31:0] i2c_data;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_start = 0;
    int proto_err = 0;
    logic [31:0] obs_data[$];
    int          obs_cyc[$];

    bit never_busy = 1'b0;
    int nack_at = -1;
    int wr_idx = 0;

    lcd_cmd_sequencer #(
        .I2C_ADDR (7'h27),
        .GAP_CYC  (GAP),
        .LONG_CYC (LONG),
        .PWRUP_CYC(PWR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_byte (req_byte),
        .req_ready(req_ready),
        .backlight(backlight),
        .i2c_start(i2c_start),
        .i2c_data (i2c_data),
        .i2c_busy (i2c_busy),
        .i2c_done (i2c_done),
        .i2c_ack  (i2c_ack),
        .seq_busy (seq_busy),
        .ack_err  (ack_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected expander byte for write k (0..3) of byte b.
    function automatic logic [7:0] exp_wr(input logic [7:0] b, input logic rs, input logic bl, input int k);
        int nib;
        int en;
        nib = (k < 2) ? int'(b) / 16 : int'(b) % 16;
        en  = (k % 2 == 0) ? 1 : 0;
        return 8'(nib * 16 + int'(bl) * 8 + en * 4 + int'(rs));
    endfunction

    function automatic bit is_long(input logic rs, input logic [7:0] b);
        return (rs == 1'b0) && (b >= 8'd1) && (b <= 8'd3);
    endfunction

    // I2C writer model.
    initial begin
        i2c_busy = 1'b0;
        i2c_done = 1'b0;
        i2c_ack  = 1'b1;
        forever begin
            @(posedge clk);
            if (i2c_start === 1'b1 && !never_busy) begin
                wr_idx++;
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1 i2c_busy = 1'b1;
                repeat ($urandom_range(8, 2)) @(posedge clk);
                #1 i2c_busy = 1'b0;
                i2c_done = 1'b1;
                i2c_ack  = (wr_idx == nack_at) ? 1'b0 : 1'b1;
                @(posedge clk);
                #1 i2c_done = 1'b0;
                i2c_ack = 1'b1;
            end
        end
    end

    // Write monitor: logs every start, flags multi-cycle starts and data
    // changing while a write is in flight.
    initial begin
        logic [31:0] held;
        bit holding;
        bit prev_start;
        held = 32'd0;
        holding = 1'b0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                holding = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (i2c_start === 1'b1) begin
                    obs_data.push_back(i2c_data);
                    obs_cyc.push_back(cyc);
                    n_start++;
                    if (prev_start) proto_err++;
                    held = i2c_data;
                    holding = 1'b1;
                end else if (holding) begin
                    if (i2c_data !== held) proto_err++;
                    if (i2c_done === 1'b1) holding = 1'b0;
                end
                prev_start = (i2c_start === 1'b1);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL %s_ready: req_ready=%b want 1 after %0d cycles", name, req_ready, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_ready("do_reset");
    endtask

    task automatic send(input logic rs, input logic [7:0] b, input logic bl, output int dur);
        int t0;
        wait_ready("send_idle");
        obs_data.delete();
        obs_cyc.delete();
        backlight = bl;
        req_rs = rs;
        req_byte = b;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t0 = cyc;
        n_cmp++;
        if (req_ready !== 1'b0 || seq_busy !== 1'b1) begin
            n_mis++;
            $display("FAIL send_accept: req_ready=%b seq_busy=%b want 0/1", req_ready, seq_busy);
        end
        wait_ready("send_done");
        dur = cyc - t0;
    endtask

    task automatic check_writes(input string name, input logic rs, input logic [7:0] b,
                                input logic bl, input int base, input int total);
        logic [31:0] want;
        n_cmp++;
        if (obs_data.size() != total) begin
            n_mis++;
            $display("FAIL %s_count: got %0d writes want %0d", name, obs_data.size(), total);
        end
        for (int k = 0; k < 4; k++) begin
            if (base + k < obs_data.size()) begin
                want = {17'd0, 7'h27, exp_wr(b, rs, bl, k)};
                n_cmp++;
                if (obs_data[base + k] !== want) begin
                    n_mis++;
                    $display("FAIL %s_wr%0d: got %h want %h", name, k, obs_data[base + k], want);
                end
            end
        end
        n_cmp++;
        if (proto_err != 0) begin
            n_mis++;
            $display("FAIL %s_proto: got %0d start/hold errors want 0", name, proto_err);
        end
    endtask

    task automatic test_reset();
        int n;
        int t_rel;
        reset = 1'b1;
        req_valid = 1'b0;
        backlight = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0 || i2c_start !== 1'b0 || seq_busy !== 1'b1 || ack_err !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: ready/start/busy/err=%b%b%b%b want 0010",
                     req_ready, i2c_start, seq_busy, ack_err);
        end
        n_cmp++;
        if (i2c_data !== 32'd0) begin
            n_mis++;
            $display("FAIL reset_data: got %h want 0", i2c_data);
        end
        obs_data.delete();
        obs_cyc.delete();
        reset = 1'b0;
        t_rel = cyc;
        n = 0;
        while (req_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
`ifdef LCD_INIT_EN
        begin
            logic [7:0] exp_q[$];
            logic [7:0] ib[4];
            int v;
            ib = '{8'h28, 8'h0C, 8'h06, 8'h01};
            for (int i = 0; i < 4; i++) begin
                v = (i == 3) ? 2 : 3;
                exp_q.push_back(8'(v * 16 + 8 + 4));
                exp_q.push_back(8'(v * 16 + 8));
            end
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) exp_q.push_back(exp_wr(ib[i], 1'b0, 1'b1, k));
            n_cmp++;
            if (obs_data.size() != exp_q.size()) begin
                n_mis++;
                $display("FAIL init_count: got %0d writes want %0d", obs_data.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
                n_cmp++;
                if (obs_data[i] !== {17'd0, 7'h27, exp_q[i]}) begin
                    n_mis++;
                    $display("FAIL init_wr%0d: got %h want %h", i, obs_data[i], {17'd0, 7'h27, exp_q[i]});
                end
            end
            if (obs_cyc.size() > 0) begin
                n_cmp++;
                if (obs_cyc[0] - t_rel < int'(PWR)) begin
                    n_mis++;
                    $display("FAIL init_pwrup: first write after %0d cycles want >= %0d", obs_cyc[0] - t_rel, PWR);
                end
            end
        end
`else
        n_cmp++;
        if (n != int'(PWR)) begin
            n_mis++;
            $display("FAIL reset_pwrup_len: ready after %0d cycles want %0d (start %0d)", n, PWR, t_rel);
        end
        n_cmp++;
        if (obs_data.size() != 0) begin
            n_mis++;
            $display("FAIL reset_no_write: got %0d writes want 0", obs_data.size());
        end
`endif
    endtask

    task automatic test_data_byte();
        int dur;
        logic [7:0] lit[4];
        lit = '{8'h4D, 8'h49, 8'h1D, 8'h19};
        send(1'b1, 8'h41, 1'b1, dur);
        check_writes("data41", 1'b1, 8'h41, 1'b1, 0, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_data.size()) begin
                n_cmp++;
                if (obs_data[k][7:0] !== lit[k] || obs_data[k][14:8] !== 7'h27) begin
                    n_mis++;
                    $display("FAIL data41_lit%0d: got %h want addr 27 byte %h", k, obs_data[k], lit[k]);
                end
            end
        end
        n_cmp++;
        if (ack_err !== 1'b0 || seq_busy !== 1'b0) begin
            n_mis++;
            $display("FAIL data41_status: ack_err=%b seq_busy=%b want 0/0", ack_err, seq_busy);
        end
    endtask

    task automatic test_gap_boundary();
        logic [8:0] tbl[6];
        int dur;
        tbl = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h000, 9'h101};
        for (int i = 0; i < 6; i++) begin
            send(tbl[i][8], tbl[i][7:0], 1'b1, dur);
            check_writes("gap", tbl[i][8], tbl[i][7:0], 1'b1, 0, 4);
            n_cmp++;
            if (is_long(tbl[i][8], tbl[i][7:0]) != (dur >= int'(GAP) + int'(LONG))) begin
                n_mis++;
                $display("FAIL gap_len: rs=%b byte=%h took %0d cycles, long expected=%0d (limit %0d)",
                         tbl[i][8], tbl[i][7:0], dur, is_long(tbl[i][8], tbl[i][7:0]), int'(GAP) + int'(LONG));
            end
        end
    endtask

    task automatic test_random();
        logic       rs;
        logic       bl;
        logic [7:0] b;
        int         dur;
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom);
            bl = 1'($urandom);
            b  = 8'($urandom);
            send(rs, b, bl, dur);
            check_writes("rand", rs, b, bl, 0, 4);
            n_cmp++;
            if (is_long(rs, b) != (dur >= int'(GAP) + int'(LONG))) begin
                n_mis++;
                $display("FAIL rand_len: rs=%b byte=%h took %0d cycles", rs, b, dur);
            end
        end
    endtask

    task automatic test_back_to_back();
        wait_ready("b2b_idle");
        obs_data.delete();
        obs_cyc.delete();
        backlight = 1'b1;
        req_rs = 1'b1;
        req_byte = 8'hC3;
        req_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL b2b_ready_drop: req_ready=%b want 0", req_ready);
        end
        // Second request held valid while the first is still in flight.
        req_rs = 1'b0;
        req_byte = 8'h5A;
        wait_ready("b2b_mid");
        @(negedge clk);
        req_valid = 1'b0;
        wait_ready("b2b_done");
        check_writes("b2b_a", 1'b1, 8'hC3, 1'b1, 0, 8);
        check_writes("b2b_b", 1'b0, 8'h5A, 1'b1, 4, 8);
    endtask

    task automatic test_nack();
        int dur;
        n_cmp++;
        if (ack_err !== 1'b0) begin
            n_mis++;
            $display("FAIL nack_pre: ack_err=%b want 0", ack_err);
        end
        wait_ready("nack_idle");
        wr_idx = 0;
        nack_at = 2;
        send(1'b1, 8'h96, 1'b0, dur);
        nack_at = -1;
        check_writes("nack", 1'b1, 8'h96, 1'b0, 0, 4);
        n_cmp++;
        if (ack_err !== 1'b1) begin
            n_mis++;
            $display("FAIL nack_err: ack_err=%b want 1", ack_err);
        end
        send(1'b0, 8'h80, 1'b1, dur);
        check_writes("nack_next", 1'b0, 8'h80, 1'b1, 0, 4);
        n_cmp++;
        if (ack_err !== 1'b1) begin
            n_mis++;
            $display("FAIL nack_sticky: ack_err=%b want 1", ack_err);
        end
    endtask

    task automatic test_timeout();
        int n;
        int delta;
        do_reset();
        never_busy = 1'b1;
        n_cmp++;
        if (ack_err !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_pre: ack_err=%b want 0", ack_err);
        end
        obs_data.delete();
        obs_cyc.delete();
        backlight = 1'b1;
        req_rs = 1'b1;
        req_byte = 8'hA5;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (ack_err !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (ack_err !== 1'b1 || obs_cyc.size() == 0) begin
            n_mis++;
            $display("FAIL timeout_err: ack_err=%b starts=%0d want 1 and >=1", ack_err, obs_cyc.size());
        end else begin
            delta = cyc - obs_cyc[0];
            n_cmp++;
            if (delta < 1024 || delta > 1026) begin
                n_mis++;
                $display("FAIL timeout_len: ack_err after %0d cycles want 1024..1026", delta);
            end
        end
        wait_ready("timeout_done");
        never_busy = 1'b0;
        check_writes("timeout", 1'b1, 8'hA5, 1'b1, 0, 4);
    endtask

    task automatic test_reset_mid();
        int n;
        int starts0;
        wait_ready("mid_idle");
        obs_data.delete();
        obs_cyc.delete();
        req_rs = 1'b0;
        req_byte = 8'h28;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (i2c_busy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (i2c_busy !== 1'b1) begin
            n_mis++;
            $display("FAIL mid_busy: i2c_busy=%b want 1", i2c_busy);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (i2c_start !== 1'b0 || seq_busy !== 1'b1 || req_ready !== 1'b0 || ack_err !== 1'b0) begin
            n_mis++;
            $display("FAIL mid_ctrl: start/busy/ready/err=%b%b%b%b want 0100",
                     i2c_start, seq_busy, req_ready, ack_err);
        end
        n_cmp++;
        if (i2c_data !== 32'd0) begin
            n_mis++;
            $display("FAIL mid_data: got %h want 0", i2c_data);
        end
        starts0 = n_start;
        reset = 1'b0;
        repeat (int'(PWR)) @(negedge clk);
        n_cmp++;
        if (n_start != starts0) begin
            n_mis++;
            $display("FAIL mid_quiet: got %0d starts during power-up want 0", n_start - starts0);
        end
        wait_ready("mid_post");
    endtask

    initial begin
        test_reset();
        test_data_byte();
        test_gap_boundary();
        test_random();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
